// File: rtl/wrf_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS frame sources onto one WR fabric stream,
// with inter-frame gap insertion and an over-length frame watchdog.
module wrf_tx_arbiter #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned IFG_CYCLES      = 4,
    parameter int unsigned MAX_FRAME_WORDS = 760
) (
    input  logic                      wrf_clk,
    input  logic                      wrf_rst,
    input  logic [NUM_PORTS-1:0]      in_valid,
    input  logic [NUM_PORTS-1:0]      in_last,
    input  logic [16*NUM_PORTS-1:0]   in_data,
    output logic [NUM_PORTS-1:0]      in_ready,
    output logic                      wrf_valid,
    output logic                      wrf_last,
    output logic [15:0]               wrf_data,
    input  logic                      wrf_ready,
    output logic [1:0]                grant,
    output logic [15:0]               frame_cnt,
    output logic                      err_overlong
);

    typedef enum logic [1:0] {StIdle, StXfer, StDrop, StGap} state_e;

    localparam logic [10:0] TruncAt    = 11'(MAX_FRAME_WORDS - 1);
    localparam logic [7:0]  GapLoad    = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);
    localparam state_e      AfterFrame = (IFG_CYCLES == 0) ? StIdle : StGap;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_q, err_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;

    logic                 sel_valid;
    logic                 sel_last;
    logic [15:0]          sel_data;
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 found;
    logic [1:0]           pick;
    logic                 trunc;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 16'h0;
        grant_oh  = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (grant_q == 2'(p)) begin
                sel_valid   = in_valid[p];
                sel_last    = in_last[p];
                sel_data    = in_data[16*p +: 16];
                grant_oh[p] = 1'b1;
            end
        end
    end

    // Scan from rr+1 so the most recently served port is considered last.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (!found && in_valid[p] && ((int'(rr_q) + i) % int'(NUM_PORTS) == p)) begin
                    found = 1'b1;
                    pick  = 2'(p);
                end
            end
        end
    end

    assign trunc = (word_cnt_q == TruncAt);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        in_ready    = '0;
        wrf_valid   = 1'b0;
        wrf_last    = 1'b0;
        wrf_data    = 16'h0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d    = pick;
                    word_cnt_d = 11'd0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                wrf_valid = sel_valid;
                wrf_data  = sel_data;
                wrf_last  = sel_last | trunc;
                in_ready  = grant_oh & {NUM_PORTS{wrf_ready}};
                if (sel_valid && wrf_ready) begin
                    if (sel_last) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        rr_d        = grant_q;
                        word_cnt_d  = 11'd0;
                        gap_cnt_d   = GapLoad;
                        state_d     = AfterFrame;
                    end else if (trunc) begin
                        // Frame closed early on the output; the source tail is drained in DROP.
                        err_d       = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        word_cnt_d  = 11'd0;
                        state_d     = StDrop;
                    end else begin
                        word_cnt_d = word_cnt_q + 11'd1;
                    end
                end
            end
            StDrop: begin
                in_ready = grant_oh;
                if (sel_valid && sel_last) begin
                    rr_d      = grant_q;
                    gap_cnt_d = GapLoad;
                    state_d   = AfterFrame;
                end
            end
            StGap: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wrf_clk) begin
        if (wrf_rst) begin
            state_q     <= StIdle;
            grant_q     <= 2'd0;
            rr_q        <= 2'd0;
            frame_cnt_q <= 16'd0;
            err_q       <= 1'b0;
            word_cnt_q  <= 11'd0;
            gap_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign grant        = grant_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_overlong = err_q;

endmodule

// File: tb/tb_wrf_tx_arbiter.sv
// Directed bench for wrf_tx_arbiter: one instance with the default frame limit and one with a
// 16-word limit, driven from shared behavioural frame sources.
module tb_wrf_tx_arbiter;

    localparam int IFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        rdy;
    logic [1:0]  src_valid, src_last;
    logic [31:0] src_data;

    logic [1:0]  a_in_valid, a_in_last, a_in_ready, a_grant;
    logic [1:0]  b_in_valid, b_in_last, b_in_ready, b_grant;
    logic        a_valid, a_last, a_err, b_valid, b_last, b_err;
    logic [15:0] a_data, a_fcnt, b_data, b_fcnt;

    assign a_in_valid = sel ? 2'b00 : src_valid;
    assign a_in_last  = sel ? 2'b00 : src_last;
    assign b_in_valid = sel ? src_valid : 2'b00;
    assign b_in_last  = sel ? src_last : 2'b00;

    wrf_tx_arbiter #(.NUM_PORTS(2), .IFG_CYCLES(IFG), .MAX_FRAME_WORDS(760)) dut_a (
        .wrf_clk(clk), .wrf_rst(rst), .in_valid(a_in_valid), .in_last(a_in_last),
        .in_data(src_data), .in_ready(a_in_ready), .wrf_valid(a_valid), .wrf_last(a_last),
        .wrf_data(a_data), .wrf_ready(rdy), .grant(a_grant), .frame_cnt(a_fcnt),
        .err_overlong(a_err)
    );

    wrf_tx_arbiter #(.NUM_PORTS(2), .IFG_CYCLES(IFG), .MAX_FRAME_WORDS(16)) dut_b (
        .wrf_clk(clk), .wrf_rst(rst), .in_valid(b_in_valid), .in_last(b_in_last),
        .in_data(src_data), .in_ready(b_in_ready), .wrf_valid(b_valid), .wrf_last(b_last),
        .wrf_data(b_data), .wrf_ready(rdy), .grant(b_grant), .frame_cnt(b_fcnt),
        .err_overlong(b_err)
    );

    logic [1:0]  o_in_ready, o_grant;
    logic        o_valid, o_last, o_err;
    logic [15:0] o_data, o_fcnt;
    assign o_in_ready = sel ? b_in_ready : a_in_ready;
    assign o_grant    = sel ? b_grant : a_grant;
    assign o_valid    = sel ? b_valid : a_valid;
    assign o_last     = sel ? b_last : a_last;
    assign o_err      = sel ? b_err : a_err;
    assign o_data     = sel ? b_data : a_data;
    assign o_fcnt     = sel ? b_fcnt : a_fcnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cnt, err_cyc, track_bad;
    logic        rdy_toggle;
    logic [15:0] q_data[$];
    bit          q_last[$];
    logic [1:0]  q_grant[$];
    int          q_cyc[$];

    int s_frames[2], s_len[2], s_len_next[2], s_idx[2], s_seq[2], s_delay[2];

    task automatic drive_src();
        for (int p = 0; p < 2; p++) begin
            logic act;
            act = (s_frames[p] > 0) && (s_delay[p] == 0);
            src_valid[p] = act;
            src_last[p]  = act && (s_idx[p] == s_len[p] - 1);
            src_data[16*p +: 16] = act ? {4'(p), 12'(s_seq[p])} : 16'h0;
        end
    endtask

    task automatic setup_port(input int p, input int frames, input int len, input int len_next,
                              input int delay);
        s_frames[p] = frames; s_len[p] = len; s_len_next[p] = len_next;
        s_idx[p] = 0; s_seq[p] = 0; s_delay[p] = delay;
    endtask

    task automatic clear_logs();
        q_data.delete(); q_last.delete(); q_grant.delete(); q_cyc.delete();
        err_cnt = 0; err_cyc = -1; track_bad = 0;
    endtask

    // One clock: observe before the edge, then advance sources after it.
    task automatic step();
        logic [1:0] hs;
        #2;
        hs = src_valid & o_in_ready;
        if (o_valid && rdy) begin
            q_data.push_back(o_data); q_last.push_back(o_last);
            q_grant.push_back(o_grant); q_cyc.push_back(cyc);
        end
        if (o_valid && (o_in_ready !== (rdy ? (2'b01 << o_grant) : 2'b00))) track_bad++;
        if (o_err) begin err_cnt++; err_cyc = cyc; end
        @(posedge clk); #1;
        cyc++;
        if (rdy_toggle) rdy = ~rdy;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
                s_seq[p]++;
                if (src_last[p]) begin
                    s_idx[p] = 0; s_frames[p]--; s_len[p] = s_len_next[p];
                end else begin
                    s_idx[p]++;
                end
            end else if (s_delay[p] > 0) begin
                s_delay[p]--;
            end
        end
        drive_src();
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; rdy_toggle = 1'b0;
        setup_port(0, 0, 1, 1, 0); setup_port(1, 0, 1, 1, 0);
        drive_src();
        @(posedge clk); #1;
        rst = 1'b0; cyc++;
        clear_logs();
    endtask

    task automatic run(input int limit, input int tail, output bit timeout);
        int n;
        n = 0;
        while ((s_frames[0] > 0 || s_frames[1] > 0) && n < limit) begin step(); n++; end
        timeout = (n >= limit);
        repeat (tail) step();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        #1;
        checks++; if (o_in_ready !== 2'b00) begin errors++;
            $display("FAIL reset_in_ready: got %b want 00", o_in_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_last !== 1'b0) begin errors++;
            $display("FAIL reset_last: got %b want 0", o_last); end
        checks++; if (o_data !== 16'h0) begin errors++;
            $display("FAIL reset_data: got %h want 0000", o_data); end
        checks++; if (o_grant !== 2'd0) begin errors++;
            $display("FAIL reset_grant: got %0d want 0", o_grant); end
        checks++; if (o_fcnt !== 16'd0) begin errors++;
            $display("FAIL reset_frame_cnt: got %0d want 0", o_fcnt); end
        checks++; if (o_err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b want 0", o_err); end
    endtask

    task automatic test_single_frame();
        bit to; int t0; int bad; int lasts;
        sel = 1'b0;
        do_reset();
        setup_port(0, 2, 126, 2, 0); drive_src();
        t0 = cyc;
        run(1000, 10, to);
        bad = 0; lasts = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (i < 126 && q_data[i] !== {4'h0, 12'(i)}) bad++;
            if (q_last[i]) lasts++;
        end
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got 1 want 0"); end
        checks++; if (q_data.size() != 128) begin errors++;
            $display("FAIL single_beats: got %0d want 128", q_data.size()); end
        checks++; if (q_last[125] !== 1'b1) begin errors++;
            $display("FAIL single_last_pos: got %b want 1", q_last[125]); end
        checks++; if (lasts != 2) begin errors++;
            $display("FAIL single_last_count: got %0d want 2", lasts); end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL single_data: got %0d bad words want 0", bad); end
        checks++; if (q_cyc[0] - t0 != 1) begin errors++;
            $display("FAIL single_latency: got %0d want 1", q_cyc[0] - t0); end
        checks++; if (q_cyc[125] - q_cyc[0] != 125) begin errors++;
            $display("FAIL single_stream: got %0d want 125", q_cyc[125] - q_cyc[0]); end
        checks++; if (q_cyc[126] - q_cyc[125] != IFG + 2) begin errors++;
            $display("FAIL single_ifg: got %0d want %0d", q_cyc[126] - q_cyc[125], IFG + 2); end
        checks++; if (o_fcnt !== 16'd2) begin errors++;
            $display("FAIL single_frame_cnt: got %0d want 2", o_fcnt); end
    endtask

    task automatic test_round_robin();
        bit to; int bad; int exp_seq[2]; int cur; logic [1:0] fg[$]; logic [7:0] gseq;
        sel = 1'b0;
        do_reset();
        setup_port(0, 2, 10, 10, 0); setup_port(1, 2, 10, 10, 1); drive_src();
        run(500, 10, to);
        bad = 0; exp_seq[0] = 0; exp_seq[1] = 0; cur = -1;
        for (int i = 0; i < q_data.size(); i++) begin
            int p;
            p = int'(q_data[i][15:12]);
            if (i == 0 || q_last[i-1]) begin fg.push_back(q_grant[i]); cur = p; end
            if (p != cur || p > 1 || 2'(p) !== q_grant[i]) bad++;
            else begin
                if (int'(q_data[i][11:0]) != exp_seq[p]) bad++;
                exp_seq[p]++;
            end
        end
        gseq = {fg[0], fg[1], fg[2], fg[3]};
        checks++; if (to) begin errors++; $display("FAIL rr_timeout: got 1 want 0"); end
        checks++; if (fg.size() != 4) begin errors++;
            $display("FAIL rr_frames: got %0d want 4", fg.size()); end
        checks++; if (gseq !== 8'b00_01_00_01) begin errors++;
            $display("FAIL rr_grant_seq: got %b want 00010001", gseq); end
        checks++; if (bad != 0 || q_data.size() != 40) begin errors++;
            $display("FAIL rr_interleave: got %0d bad of %0d beats want 0 of 40",
                     bad, q_data.size()); end
        checks++; if (o_fcnt !== 16'd4) begin errors++;
            $display("FAIL rr_frame_cnt: got %0d want 4", o_fcnt); end
    endtask

    task automatic test_backpressure();
        bit to; int bad; int lasts;
        sel = 1'b0;
        do_reset();
        setup_port(1, 1, 12, 12, 0); drive_src();
        rdy_toggle = 1'b1;
        run(300, 6, to);
        rdy_toggle = 1'b0; rdy = 1'b1;
        bad = 0; lasts = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (q_data[i] !== {4'h1, 12'(i)}) bad++;
            if (q_last[i]) lasts++;
        end
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got 1 want 0"); end
        checks++; if (q_data.size() != 12 || bad != 0) begin errors++;
            $display("FAIL bp_data: got %0d beats %0d bad want 12 beats 0 bad",
                     q_data.size(), bad); end
        checks++; if (lasts != 1 || q_last[11] !== 1'b1) begin errors++;
            $display("FAIL bp_last: got %0d lasts want 1 on beat 12", lasts); end
        checks++; if (track_bad != 0) begin errors++;
            $display("FAIL bp_in_ready: got %0d mismatching cycles want 0", track_bad); end
    endtask

    task automatic test_overlong();
        bit to; int bad; int lasts;
        sel = 1'b1;
        do_reset();
        setup_port(0, 2, 20, 3, 0); drive_src();
        run(500, 10, to);
        bad = 0; lasts = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (i < 16 && q_data[i] !== {4'h0, 12'(i)}) bad++;
            if (q_last[i]) lasts++;
        end
        checks++; if (to) begin errors++; $display("FAIL ovl_timeout: got 1 want 0"); end
        checks++; if (q_data.size() != 19 || bad != 0) begin errors++;
            $display("FAIL ovl_beats: got %0d beats %0d bad want 19 beats 0 bad",
                     q_data.size(), bad); end
        checks++; if (q_last[15] !== 1'b1 || lasts != 2) begin errors++;
            $display("FAIL ovl_last: got %b at beat 16, %0d lasts want 1, 2", q_last[15], lasts);
        end
        checks++; if (err_cnt != 1) begin errors++;
            $display("FAIL ovl_err_count: got %0d want 1", err_cnt); end
        checks++; if (err_cyc != q_cyc[15] + 1) begin errors++;
            $display("FAIL ovl_err_time: got %0d want %0d", err_cyc, q_cyc[15] + 1); end
        checks++; if (q_data[16] !== {4'h0, 12'd20}) begin errors++;
            $display("FAIL ovl_next_frame: got %h want 0014", q_data[16]); end
        checks++; if (o_fcnt !== 16'd2) begin errors++;
            $display("FAIL ovl_frame_cnt: got %0d want 2", o_fcnt); end
    endtask

    task automatic test_exact_limit();
        bit to; int lasts;
        sel = 1'b1;
        do_reset();
        setup_port(0, 2, 16, 2, 0); drive_src();
        run(500, 10, to);
        lasts = 0;
        for (int i = 0; i < q_data.size(); i++) if (q_last[i]) lasts++;
        checks++; if (to) begin errors++; $display("FAIL exact_timeout: got 1 want 0"); end
        checks++; if (q_data.size() != 18 || q_last[15] !== 1'b1 || lasts != 2) begin errors++;
            $display("FAIL exact_beats: got %0d beats %0d lasts want 18, 2",
                     q_data.size(), lasts); end
        checks++; if (err_cnt != 0) begin errors++;
            $display("FAIL exact_err: got %0d pulses want 0", err_cnt); end
        checks++; if (q_data[16] !== {4'h0, 12'd16}) begin errors++;
            $display("FAIL exact_no_drop: got %h want 0010", q_data[16]); end
    endtask

    task automatic test_reset_mid_frame();
        bit to; int n; int lasts;
        sel = 1'b0;
        do_reset();
        setup_port(0, 2, 3, 10, 0); drive_src();
        n = 0;
        while (q_data.size() < 7 && n < 200) begin step(); n++; end
        #1;
        lasts = 0;
        for (int i = 0; i < q_data.size(); i++) if (q_last[i]) lasts++;
        checks++; if (n >= 200) begin errors++; $display("FAIL rstmid_timeout: got 1 want 0"); end
        checks++; if (o_valid !== 1'b1 || o_data !== 16'h0007 || o_fcnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_pre: got v=%b d=%h cnt=%0d want 1 0007 1",
                     o_valid, o_data, o_fcnt); end
        checks++; if (lasts != 1) begin errors++;
            $display("FAIL rstmid_lasts: got %0d want 1", lasts); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc++;
        #1;
        checks++; if (o_in_ready !== 2'b00 || o_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_idle: got rdy=%b v=%b want 00 0", o_in_ready, o_valid); end
        checks++; if (o_fcnt !== 16'd0 || o_grant !== 2'd0) begin errors++;
            $display("FAIL rstmid_regs: got cnt=%0d grant=%0d want 0 0", o_fcnt, o_grant); end
        clear_logs();
        setup_port(0, 1, 2, 2, 0); setup_port(1, 1, 2, 2, 0); drive_src();
        run(200, 4, to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_timeout2: got 1 want 0"); end
        checks++; if (q_grant[0] !== 2'd1 || q_data[0] !== 16'h1000) begin errors++;
            $display("FAIL rstmid_first_grant: got g=%0d d=%h want 1 1000",
                     q_grant[0], q_data[0]); end
        checks++; if (q_grant[2] !== 2'd0 || o_fcnt !== 16'd2) begin errors++;
            $display("FAIL rstmid_second: got g=%0d cnt=%0d want 0 2", q_grant[2], o_fcnt); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; rdy = 1'b1; rdy_toggle = 1'b0;
        src_valid = 2'b00; src_last = 2'b00; src_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_overlong();
        test_exact_limit();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
